// File: rtl/gate_pipe_unit_if.sv
// Operand/result bus of gate_pipe_unit.
// master = operand producer plus result consumer; slave = the unit itself.
interface gate_pipe_unit_if #(
  parameter int WIDTH = 8
);
  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out1;
  logic             out_zero;
  logic             out_par;

  modport master (
    output in_valid, op, in1, in2, in3, out_ready,
    input  in_ready, out_valid, out1, out_zero, out_par
  );

  modport slave (
    input  in_valid, op, in1, in2, in3, out_ready,
    output in_ready, out_valid, out1, out_zero, out_par
  );
endinterface

// File: rtl/gate_pipe_unit.sv
// gate_pipe_unit: two-stage valid/ready pipeline that applies one of eight
// bitwise functions to three WIDTH-bit operands and registers the result
// together with zero and parity flags.
// Optional feature macro: GATE_PIPE_CNT_EN adds the saturating done_cnt
// completion counter port.
module gate_pipe_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  gate_pipe_unit_if.slave  bus
`ifdef GATE_PIPE_CNT_EN
  ,
  output logic [CNT_W-1:0] done_cnt
`endif
);

  typedef enum logic [2:0] {
    OP_AND     = 3'b000,
    OP_OR      = 3'b001,
    OP_XOR     = 3'b010,
    OP_NAND    = 3'b011,
    OP_NOR     = 3'b100,
    OP_XNOR_AC = 3'b101,
    OP_NOT_B   = 3'b110,
    OP_MAJ     = 3'b111
  } op_e;

  // Stage 1 (operand) registers
  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_c;

  // Stage 2 (result) registers
  logic             s2_valid;
  logic [WIDTH-1:0] s2_res;
  logic             s2_zero;
  logic             s2_par;

  logic             adv1;
  logic             adv2;
  logic             accept;
  logic [WIDTH-1:0] fn_res;

  // Pipeline advance: stage 2 frees when empty or drained; stage 1 follows it.
  assign adv2         = !s2_valid || bus.out_ready;
  assign adv1         = adv2;
  assign bus.in_ready = !s1_valid || adv1;
  assign accept       = bus.in_valid && bus.in_ready;

  // Stage 1: capture a beat whenever the stage can take one.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  // NOTE: the operand payload is deliberately not reset; s1_valid alone
  // decides whether it means anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (accept) begin
        s1_op <= op_e'(bus.op);
        s1_a  <= bus.in1;
        s1_b  <= bus.in2;
        s1_c  <= bus.in3;
      end
    end
  end

  // Function network evaluated on the stage-1 operands.
  // NOTE: the default assignment ahead of the case keeps this purely
  // combinational for every op value.
  always_comb begin
    fn_res = '0;
    unique case (s1_op)
      OP_AND:     fn_res = s1_a & s1_b;
      OP_OR:      fn_res = s1_a | s1_b;
      OP_XOR:     fn_res = s1_a ^ s1_b;
      OP_NAND:    fn_res = ~(s1_a & s1_b);
      OP_NOR:     fn_res = ~(s1_a | s1_b);
      OP_XNOR_AC: fn_res = ~(s1_a ^ s1_c);
      // ((a&b)|~b)&~b reduces to ~b
      OP_NOT_B:   fn_res = ~s1_b;
      OP_MAJ:     fn_res = (s1_a & s1_b) | (s1_a & s1_c) | (s1_b & s1_c);
      default:    fn_res = '0;
    endcase
  end

  // Stage 2: register result and flags; a bubble clears valid but keeps data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_zero  <= 1'b0;
      s2_par   <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res  <= fn_res;
        s2_zero <= ~|fn_res;
        s2_par  <= ^fn_res;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out1      = s2_res;
  assign bus.out_zero  = s2_zero;
  assign bus.out_par   = s2_par;

`ifdef GATE_PIPE_CNT_EN
  // Completion counter: one per result handshake, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (s2_valid && bus.out_ready && (done_cnt != {CNT_W{1'b1}})) begin
      done_cnt <= done_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_pipe_unit.sv
// Self-checking bench for gate_pipe_unit (WIDTH=8, CNT_W=2).
// A queue-based model tracks every accepted beat and where it sits in the
// pipe; a negedge compare process checks the DUT against it every cycle.
module tb_gate_pipe_unit;

  localparam int W  = 8;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
`ifdef GATE_PIPE_CNT_EN
  logic [CW-1:0] done_cnt;
`endif

  gate_pipe_unit_if #(.WIDTH(W)) bus ();

  gate_pipe_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef GATE_PIPE_CNT_EN
    ,
    .done_cnt (done_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference function: evaluated one lane at a time from the truth rules.
  function automatic logic [W-1:0] ref_fn(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] c);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      case (op)
        3'd0: r[i] = a[i] && b[i];
        3'd1: r[i] = a[i] || b[i];
        3'd2: r[i] = (a[i] != b[i]);
        3'd3: r[i] = !(a[i] && b[i]);
        3'd4: r[i] = !(a[i] || b[i]);
        3'd5: r[i] = (a[i] == c[i]);
        3'd6: r[i] = !b[i];
        default: r[i] = (ones >= 2);
      endcase
    end
    return r;
  endfunction

  // Model: beats in flight, oldest first, each tagged with its stage (1 or 2).
  typedef struct {
    logic [W-1:0] res;
    int           stg;
  } beat_t;
  beat_t q[$];

  function automatic bit m_s2_occ();
    return (q.size() > 0) && (q[0].stg == 2);
  endfunction

  function automatic bit m_s1_occ();
    return (q.size() == 2) || ((q.size() == 1) && (q[0].stg == 1));
  endfunction

  function automatic bit m_in_ready();
    return !(m_s1_occ() && m_s2_occ() && !bus.out_ready);
  endfunction

  // Model update on each rising edge from the bench-driven inputs.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      bit acc;
      bit s2_free;
      acc     = bus.in_valid && m_in_ready();
      s2_free = !m_s2_occ() || bus.out_ready;
      if (m_s2_occ() && bus.out_ready) void'(q.pop_front());
      if (s2_free && (q.size() > 0) && (q[0].stg == 1)) q[0].stg = 2;
      if (acc) begin
        beat_t nb;
        nb.res = ref_fn(bus.op, bus.in1, bus.in2, bus.in3);
        nb.stg = 1;
        q.push_back(nb);
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  int dut_emits     = 0;
  bit saw_ready_low = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", bus.out_valid, m_s2_occ());
      check("in_ready", bus.in_ready, m_in_ready());
      if (m_s2_occ()) begin
        check("out1", bus.out1, q[0].res);
        check("out_zero", bus.out_zero, (q[0].res == '0));
        check("out_par", bus.out_par, ($countones(q[0].res) % 2));
      end
      if (!bus.in_ready) saw_ready_low = 1'b1;
      if (bus.out_valid && bus.out_ready) dut_emits++;
    end
  end

  // One beat into an empty pipe with out_ready high; pins latency and value.
  task automatic run_single(input string name, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] c,
                            input logic [W-1:0] er, input logic ez, input logic ep);
    bus.op = op; bus.in1 = a; bus.in2 = b; bus.in3 = c;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({name, "_lat1_valid"}, bus.out_valid, 1'b0);
    @(posedge clk); #1;
    check({name, "_lat2_valid"}, bus.out_valid, 1'b1);
    check({name, "_out1"}, bus.out1, er);
    check({name, "_zero"}, bus.out_zero, ez);
    check({name, "_par"}, bus.out_par, ep);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0) && (n < 50)) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drain_left"}, q.size(), 0);
  endtask

  // Stream vectors
  logic [2:0]   s_op[5] = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd4};
  logic [W-1:0] s_a[5]  = '{8'h0F, 8'h11, 8'h5A, 8'hCC, 8'h00};
  logic [W-1:0] s_b[5]  = '{8'hFF, 8'h22, 8'hA5, 8'hAA, 8'h00};
  logic [W-1:0] s_c[5]  = '{8'h00, 8'h00, 8'h00, 8'hF0, 8'h00};

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int emits0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.op = 3'd0; bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, one cycle after rst deasserts
    @(posedge clk); #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out1", bus.out1, 8'h00);
    check("rst_zero", bus.out_zero, 1'b0);
    check("rst_par", bus.out_par, 1'b0);
`ifdef GATE_PIPE_CNT_EN
    check("rst_done_cnt", done_cnt, 2'd0);
`endif

    // Pin the model with hand-computed values
    check("model_and", ref_fn(3'd0, 8'hF0, 8'h3C, 8'h00), 8'h30);
    check("model_xnor_ac", ref_fn(3'd5, 8'hAA, 8'h00, 8'hAA), 8'hFF);
    check("model_not_b", ref_fn(3'd6, 8'h00, 8'hFF, 8'h00), 8'h00);
    check("model_maj", ref_fn(3'd7, 8'hCC, 8'hAA, 8'hF0), 8'hE8);

    // Directed single beats with literal expectations
    run_single("and",  3'd0, 8'hF0, 8'h3C, 8'h00, 8'h30, 1'b0, 1'b0);
    run_single("xnac", 3'd5, 8'hAA, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0);
    run_single("notb", 3'd6, 8'h12, 8'hFF, 8'h34, 8'h00, 1'b1, 1'b0);
    run_single("maj",  3'd7, 8'hCC, 8'hAA, 8'hF0, 8'hE8, 1'b0, 1'b0);
    run_single("nand", 3'd3, 8'hFF, 8'h01, 8'h00, 8'hFE, 1'b0, 1'b1);
    drain("singles");

    // Five back-to-back beats with a three-cycle consumer stall
    emits0 = dut_emits;
    saw_ready_low = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          bit rdy;
          int tries;
          bus.op = s_op[k]; bus.in1 = s_a[k]; bus.in2 = s_b[k]; bus.in3 = s_c[k];
          bus.in_valid = 1'b1;
          tries = 0;
          do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            tries++;
          end while (!rdy && (tries < 20));
          if (!rdy) check("stream_accept_timeout", 1'b0, 1'b1);
          #1;
        end
        bus.in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("stream");
    check("stream_emits", dut_emits - emits0, 5);
    check("stream_in_ready_fell", saw_ready_low, 1'b1);

    // Reset with two beats in flight
    bus.op = 3'd1; bus.in1 = 8'h80; bus.in2 = 8'h01; bus.in3 = 8'h00;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in1 = 8'h40;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    rst = 1'b0;
    emits0 = dut_emits;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_stale", dut_emits - emits0, 0);
    check("midrst_out_valid_after", bus.out_valid, 1'b0);

`ifdef GATE_PIPE_CNT_EN
    // Saturating counter with CNT_W=2
    check("cnt_after_rst", done_cnt, 2'd0);
    for (int k = 0; k < 4; k++)
      run_single("cnt", 3'd2, 8'h0F, 8'hF0, 8'h00, 8'hFF, 1'b0, 1'b0);
    check("cnt_four", done_cnt, 2'd3);
    for (int k = 0; k < 2; k++)
      run_single("cnt_sat", 3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    check("cnt_saturated", done_cnt, 2'd3);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
